// File: rtl/sar_sample_averager.sv
// sar_sample_averager
//
// Sits after the SAR conversion register. It captures each finished
// conversion word and accumulates 2^LOG2_AVG consecutive words. It then
// pushes their average into a 2-entry FIFO, which drains over a valid/ready
// stream. An average that finds the FIFO full, with no pop in the same
// cycle, is dropped and sets a sticky overrun flag.
//
// Optional feature macro: AVG_ROUND_EN
//   defined   -> round half up (add 2^(LOG2_AVG-1) before the shift)
//   undefined -> truncating shift
//
// Parameters
//   N_BITS    conversion word width
//   LOG2_AVG  log2 of samples per average (0..6; 0 = passthrough)
//
// Ports
//   clk                 rising-edge system clock
//   reset               synchronous active-high reset
//   quantized_voltage   conversion word from the SAR register
//   eoc                 high while the SAR resolves its last bit
//   conduct_comparison  SAR conversion-active qualifier
//   avg_enable          1 = accumulate, 0 = drop partial window / ignore captures
//   avg_data            average at the FIFO head
//   avg_valid           FIFO non-empty
//   avg_ready           consumer accepts avg_data
//   overrun             sticky, set when an average is dropped
//   clear_overrun       clears overrun (a same-cycle set wins)
//   sample_count        samples in the current window

module sar_sample_averager #(
    parameter int N_BITS   = 10,
    parameter int LOG2_AVG = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_BITS-1:0]   quantized_voltage,
    input  logic                eoc,
    input  logic                conduct_comparison,
    input  logic                avg_enable,
    output logic [N_BITS-1:0]   avg_data,
    output logic                avg_valid,
    input  logic                avg_ready,
    output logic                overrun,
    input  logic                clear_overrun,
    output logic [LOG2_AVG:0]   sample_count
);

    localparam int ACC_W = N_BITS + LOG2_AVG;
    localparam int CNT_W = LOG2_AVG + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_AVG) - 1);
`ifdef AVG_ROUND_EN
    // Half an LSB of the result; this evaluates to 0 when LOG2_AVG=0.
    localparam logic [ACC_W-1:0] RND = ACC_W'((1 << LOG2_AVG) >> 1);
`else
    localparam logic [ACC_W-1:0] RND = '0;
`endif

    logic                r_cap_pend;
    logic [ACC_W-1:0]    r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic [N_BITS-1:0]   r_mem [0:1];
    logic                r_rd_ptr;
    logic                r_wr_ptr;
    logic [1:0]          r_fcnt;
    logic                r_overrun;

    logic                w_cap;
    logic                w_last;
    logic [ACC_W-1:0]    w_sum;
    logic [ACC_W-1:0]    w_rnd;
    logic [N_BITS-1:0]   w_res;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_drop;
    logic                w_wr;

    // A capture that is still in flight is discarded if avg_enable drops.
    assign w_cap  = r_cap_pend & avg_enable;
    assign w_last = (r_cnt == CNT_LAST);

    // The sum plus rounding is at most 2^LOG2_AVG*(2^N_BITS-1)+2^(LOG2_AVG-1).
    // That still fits in ACC_W bits, so no carry is lost.
    assign w_sum  = r_acc + ACC_W'(quantized_voltage);
    assign w_rnd  = w_sum + RND;
    assign w_res  = w_rnd[ACC_W-1 -: N_BITS];

    assign avg_valid = (r_fcnt != 2'd0);
    assign w_full    = (r_fcnt == 2'd2);
    assign w_push    = w_cap & w_last;
    assign w_pop     = avg_valid & avg_ready;
    // When the FIFO is full and pops this cycle, the push reuses the freed
    // slot, because wr_ptr == rd_ptr whenever the FIFO is full.
    assign w_drop    = w_push & w_full & ~w_pop;
    assign w_wr      = w_push & ~w_drop;

    assign avg_data     = r_mem[r_rd_ptr];
    assign overrun      = r_overrun;
    assign sample_count = r_cnt;

    // Capture qualifier: the word is complete one cycle after eoc.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cap_pend <= 1'b0;
        end else begin
            r_cap_pend <= eoc & conduct_comparison & avg_enable;
        end
    end

    // Window accumulator
    always_ff @(posedge clk) begin
        if (reset || !avg_enable) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_cap) begin
            if (w_last) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Two-entry output FIFO
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) r_mem[i] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_fcnt   <= 2'd0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= w_res;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            case ({w_wr, w_pop})
                2'b10:   r_fcnt <= r_fcnt + 2'd1;
                2'b01:   r_fcnt <= r_fcnt - 2'd1;
                default: r_fcnt <= r_fcnt;
            endcase
        end
    end

    // Sticky overrun; a set in the same cycle as a clear takes priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (clear_overrun) begin
            r_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sar_sample_averager.sv
// Testbench for sar_sample_averager.
// Two instances share the stimulus: d2 (LOG2_AVG=2) and d0 (LOG2_AVG=0).
// A behavioural model tracks each instance as a list of window samples and
// a short list of pending averages. The outputs are compared to that model
// on every falling edge. Directed scenarios add literal expectations.

module tb_sar_sample_averager;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] qv = '0;
    logic       eoc = 1'b0, cc = 1'b0, en = 1'b1, rdy = 1'b0, clr = 1'b0;

    logic [9:0] d2_data, d0_data;
    logic       d2_valid, d0_valid, d2_ov, d0_ov;
    logic [2:0] d2_cnt;
    logic [0:0] d0_cnt;

    always #5 clk = ~clk;

    sar_sample_averager #(.N_BITS(10), .LOG2_AVG(2)) d2 (
        .clk(clk), .reset(reset), .quantized_voltage(qv), .eoc(eoc),
        .conduct_comparison(cc), .avg_enable(en), .avg_data(d2_data),
        .avg_valid(d2_valid), .avg_ready(rdy), .overrun(d2_ov),
        .clear_overrun(clr), .sample_count(d2_cnt));

    sar_sample_averager #(.N_BITS(10), .LOG2_AVG(0)) d0 (
        .clk(clk), .reset(reset), .quantized_voltage(qv), .eoc(eoc),
        .conduct_comparison(cc), .avg_enable(en), .avg_data(d0_data),
        .avg_valid(d0_valid), .avg_ready(rdy), .overrun(d0_ov),
        .clear_overrun(clr), .sample_count(d0_cnt));

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // index 0 -> d0 (window of 1), index 1 -> d2 (window of 4)
    int m_sum[2], m_n[2], mf[2][2], mc[2];
    bit m_ov[2];
    bit m_pend;

    function automatic int win(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    function automatic int rnd(input int k);
`ifdef AVG_ROUND_EN
        return win(k) / 2;
`else
        return 0;
`endif
    endfunction

    always @(posedge clk) begin : model
        bit cap, pop, push;
        int res;
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                m_sum[k] = 0; m_n[k] = 0; mc[k] = 0; m_ov[k] = 0;
            end
            m_pend = 0;
        end else begin
            cap = m_pend && en;
            for (int k = 0; k < 2; k++) begin
                pop  = (mc[k] > 0) && rdy;
                push = 0;
                res  = 0;
                if (!en) begin
                    m_sum[k] = 0; m_n[k] = 0;
                end else if (cap) begin
                    m_sum[k] += int'(qv);
                    m_n[k]++;
                    if (m_n[k] == win(k)) begin
                        res = (m_sum[k] + rnd(k)) / win(k);
                        push = 1;
                        m_sum[k] = 0; m_n[k] = 0;
                    end
                end
                if (pop) begin
                    mf[k][0] = mf[k][1];
                    mc[k]--;
                end
                if (push && mc[k] == 2) m_ov[k] = 1;
                else if (clr) m_ov[k] = 0;
                if (push && mc[k] < 2) begin
                    mf[k][mc[k]] = res;
                    mc[k]++;
                end
            end
            m_pend = eoc && cc && en;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("d2_valid", {31'd0, d2_valid}, (mc[1] > 0) ? 1 : 0);
            if (mc[1] > 0) chk("d2_data", {22'd0, d2_data}, mf[1][0]);
            chk("d2_overrun", {31'd0, d2_ov}, {31'd0, m_ov[1]});
            chk("d2_count", {29'd0, d2_cnt}, m_n[1]);
            chk("d0_valid", {31'd0, d0_valid}, (mc[0] > 0) ? 1 : 0);
            if (mc[0] > 0) chk("d0_data", {22'd0, d0_data}, mf[0][0]);
            chk("d0_overrun", {31'd0, d0_ov}, {31'd0, m_ov[0]});
            chk("d0_count", {31'd0, d0_cnt}, m_n[0]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1; eoc = 0; cc = 0; clr = 0;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    // Returns in the cycle after eoc; the capture happens at the end of it.
    task automatic conv(input logic [9:0] w);
        @(posedge clk); #1 qv = w; eoc = 1; cc = 1;
        @(posedge clk); #1 eoc = 0; cc = 0;
    endtask

    initial begin
        en = 1; rdy = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {31'd0, d2_valid}, 0);
        chk("rst_data", {22'd0, d2_data}, 0);
        chk("rst_overrun", {31'd0, d2_ov}, 0);
        chk("rst_count", {29'd0, d2_cnt}, 0);
        @(posedge clk); #1 reset = 0; chk_en = 1;

        // Average of 100..103, with a one-cycle valid pulse.
        conv(100); conv(101); conv(102); conv(103);
        @(negedge clk);
        chk("avg1_not_yet", {31'd0, d2_valid}, 0);
        @(negedge clk);
        chk("avg1_valid", {31'd0, d2_valid}, 1);
`ifdef AVG_ROUND_EN
        chk("avg1_data", {22'd0, d2_data}, 102);
`else
        chk("avg1_data", {22'd0, d2_data}, 101);
`endif
        chk("pass_data", {22'd0, d0_data}, 103);
        @(negedge clk);
        chk("avg1_pulse", {31'd0, d2_valid}, 0);

        // Full-scale words: passthrough and a window of four without wrap.
        do_reset();
        conv(1023);
        @(negedge clk);
        chk("pass_not_yet", {31'd0, d0_valid}, 0);
        @(negedge clk);
        chk("pass_valid", {31'd0, d0_valid}, 1);
        chk("pass_max", {22'd0, d0_data}, 1023);
        conv(1023); conv(1023); conv(1023);
        repeat (2) @(negedge clk);
        chk("max_valid", {31'd0, d2_valid}, 1);
        chk("max_data", {22'd0, d2_data}, 1023);

        // Overflow with ready low: two windows held, the third dropped.
        do_reset();
        rdy = 0;
        for (int w = 1; w <= 3; w++) repeat (4) conv(10'(w * 10));
        repeat (2) @(negedge clk);
        chk("ovf_flag", {31'd0, d2_ov}, 1);
        chk("ovf_head", {22'd0, d2_data}, 10);
        @(posedge clk); #1 clr = 1;
        @(posedge clk); #1 clr = 0;
        @(negedge clk);
        chk("ovf_cleared", {31'd0, d2_ov}, 0);
        repeat (4) conv(40);
        clr = 1;
        @(posedge clk); #1 clr = 0;
        @(negedge clk);
        chk("set_wins", {31'd0, d2_ov}, 1);

        // FIFO full: a pop in the completing cycle lets the push through.
        @(posedge clk); #1 clr = 1;
        @(posedge clk); #1 clr = 0;
        repeat (4) conv(50);
        rdy = 1;
        @(posedge clk); #1 rdy = 0;
        @(negedge clk);
        chk("pop_push_ov", {31'd0, d2_ov}, 0);
        chk("pop_push_head", {22'd0, d2_data}, 20);
        rdy = 1;

        // Dropping avg_enable discards a partial window.
        do_reset();
        conv(100); conv(200);
        @(posedge clk); #1;
        @(negedge clk);
        chk("part_count", {29'd0, d2_cnt}, 2);
        @(posedge clk); #1 en = 0;
        @(posedge clk); #1 en = 1;
        @(negedge clk);
        chk("part_cleared", {29'd0, d2_cnt}, 0);
        repeat (4) conv(8);
        repeat (2) @(negedge clk);
        chk("part_valid", {31'd0, d2_valid}, 1);
        chk("part_data", {22'd0, d2_data}, 8);

        // Reset one cycle after eoc discards the capture.
        do_reset();
        @(posedge clk); #1 qv = 500; eoc = 1; cc = 1;
        @(posedge clk); #1 eoc = 0; cc = 0; reset = 1;
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        chk("rstcap_d0_valid", {31'd0, d0_valid}, 0);
        chk("rstcap_d2_count", {29'd0, d2_cnt}, 0);
        chk("rstcap_d2_data", {22'd0, d2_data}, 0);

        // Randomized traffic, including back-to-back captures.
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            eoc   = ($urandom_range(0, 2) == 0);
            cc    = ($urandom_range(0, 7) != 0);
            en    = ($urandom_range(0, 15) != 0);
            rdy   = ($urandom_range(0, 2) == 0);
            clr   = ($urandom_range(0, 15) == 0);
            reset = ($urandom_range(0, 299) == 0);
            qv    = ($urandom_range(0, 3) == 0) ? 10'd1023 : 10'($urandom_range(0, 1023));
        end
        @(posedge clk); #1 reset = 0; eoc = 0; cc = 0; clr = 0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
